// File: rtl/instr_fetch.sv
// instr_fetch: PC owner driving a read-only RAM, with a prefetch FIFO and epoch-based branch flush
module instr_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'd0,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] ram_addr,
  output logic [1:0]  ram_rw,
  output logic        ram_enable,
  input  logic [31:0] ram_fetch,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [31:0] pc, w_pc, start;
  logic r_epoch, w_valid, w_epoch, epoch;
  logic [AW-1:0] rd_ptr, wr_ptr, nxt;
  logic [CW-1:0] count, rem;
  logic [31:0] q_instr [DEPTH];
  logic [31:0] q_pc [DEPTH];
  logic issue, pop, wr;
  always_comb begin
    pop = instr_valid && instr_ready;
    wr = w_valid && (w_epoch == epoch);
    issue = branch_taken || (int'(count) + int'(ram_enable) + int'(w_valid) < DEPTH);
    rem = count - CW'(pop);
    nxt = rd_ptr + AW'(pop);
    start = branch_taken ? branch_target : pc;
  end
  // ram_enable doubles as the stage R valid bit and ram_addr as its PC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc <= RESET_VECTOR;
      ram_addr <= RESET_VECTOR;
      ram_enable <= 1'b0;
      ram_rw <= 2'b00;
      r_epoch <= 1'b0;
      w_valid <= 1'b0;
      w_pc <= 32'd0;
      w_epoch <= 1'b0;
      epoch <= 1'b0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
      instr <= 32'd0;
      instr_pc <= 32'd0;
      instr_valid <= 1'b0;
    end else begin
      w_valid <= ram_enable;
      w_pc <= ram_addr;
      w_epoch <= r_epoch;
      ram_enable <= issue;
      ram_rw <= {1'b0, issue};
      if (issue) begin
        ram_addr <= start;
        pc <= start + 32'd1;
        r_epoch <= epoch ^ branch_taken;
      end
      if (branch_taken) begin
        epoch <= ~epoch;
        count <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        instr_valid <= 1'b0;
      end else begin
        count <= rem + CW'(wr);
        rd_ptr <= nxt;
        if (wr) wr_ptr <= wr_ptr + AW'(1);
        instr_valid <= (rem != 0) || wr;
        // head registers only move on a pop or when a word lands in an empty FIFO
        if ((pop || count == 0) && (rem != 0 || wr)) begin
          instr <= (rem == 0) ? ram_fetch : q_instr[nxt];
          instr_pc <= (rem == 0) ? w_pc : q_pc[nxt];
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr) begin
      q_instr[wr_ptr] <= ram_fetch;
      q_pc[wr_ptr] <= w_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: scoreboard bench for instr_fetch with a behavioural RAM (mem[a] = a + 0x100)
module tb_instr_fetch;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] ram_addr, ram_fetch, instr, instr_pc, branch_target;
  logic [1:0]  ram_rw;
  logic ram_enable, branch_taken, instr_valid, instr_ready;
  logic [31:0] w_addr, w_fetch, w_instr, w_pc;
  logic [1:0]  w_rw;
  logic w_en, w_valid;
  logic w_br = 1'b0;
  logic w_ready = 1'b1;
  logic [31:0] w_tgt = 32'd0;
  instr_fetch #(.RESET_VECTOR(32'd0), .DEPTH(4)) u_dut (
    .clk(clk), .rst_n(rst_n), .ram_addr(ram_addr), .ram_rw(ram_rw), .ram_enable(ram_enable),
    .ram_fetch(ram_fetch), .branch_taken(branch_taken), .branch_target(branch_target),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid), .instr_ready(instr_ready)
  );
  instr_fetch #(.RESET_VECTOR(32'hFFFF_FFFE), .DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .ram_addr(w_addr), .ram_rw(w_rw), .ram_enable(w_en),
    .ram_fetch(w_fetch), .branch_taken(w_br), .branch_target(w_tgt),
    .instr(w_instr), .instr_pc(w_pc), .instr_valid(w_valid), .instr_ready(w_ready)
  );
  always @(posedge clk) begin
    if (ram_enable && ram_rw == 2'b01) ram_fetch <= ram_addr + 32'h100;
    if (w_en && w_rw == 2'b01) w_fetch <= w_addr + 32'h100;
  end
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  logic [31:0] wq[$];
  logic [31:0] wi[$];
  always @(negedge clk) begin
    if (rst_n && w_valid && wq.size() < 4) begin
      wq.push_back(w_pc);
      wi.push_back(w_instr);
    end
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %h expected %h", tag, got, exp);
  endtask
  task automatic push_run(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) q.push_back(first + 32'(i));
  endtask
  // one clock: score any handshake just before the edge, return at edge + 1
  task automatic tick();
    logic [31:0] e;
    @(negedge clk);
    check("rw_legal", {31'd0, ram_rw[1]}, 32'd0);
    if (instr_valid && instr_ready) begin
      if (q.size() == 0) check("unexpected_pc", instr_pc, 32'hDEAD_BEEF);
      else begin
        e = q.pop_front();
        check("sb_pc", instr_pc, e);
        check("sb_instr", instr, e + 32'h100);
      end
    end
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask
  task automatic check_reset_state(input string tag);
    check({tag, "_en"}, {31'd0, ram_enable}, 32'd0);
    check({tag, "_rw"}, {30'd0, ram_rw}, 32'd0);
    check({tag, "_addr"}, ram_addr, 32'd0);
    check({tag, "_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_ipc"}, instr_pc, 32'd0);
  endtask
  int cyc;
  int reads;
  initial begin
    branch_taken = 1'b0;
    branch_target = 32'd0;
    instr_ready = 1'b1;
    #12;
    check_reset_state("rst");
    check("rst_wrap_addr", w_addr, 32'hFFFF_FFFE);
    // startup latency and back-to-back stream
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_run(0, 64);
    tick();
    check("e1_en", {31'd0, ram_enable}, 32'd1);
    check("e1_addr", ram_addr, 32'd0);
    check("e1_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("e2_valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("e3_valid", {31'd0, instr_valid}, 32'd1);
    check("e3_pc", instr_pc, 32'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("stream_valid", {31'd0, instr_valid}, 32'd1);
    end
    // back-pressure from the start
    instr_ready = 1'b0;
    do_reset();
    reads = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ram_enable) begin
        check("bp_addr", ram_addr, 32'(reads));
        reads++;
      end
    end
    check("bp_reads", 32'(reads), 32'd4);
    check("bp_en_off", {31'd0, ram_enable}, 32'd0);
    check("bp_head", instr_pc, 32'd0);
    push_run(0, 64);
    instr_ready = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("bp_resume_valid", {31'd0, instr_valid}, 32'd1);
    // branch flush with PCs 2..5 buffered or in flight
    do_reset();
    push_run(0, 64);
    for (int i = 0; i < 5; i++) tick();
    check("bf_head", instr_pc, 32'd2);
    instr_ready = 1'b0;
    tick();
    branch_taken = 1'b1;
    branch_target = 32'd20;
    tick();
    branch_taken = 1'b0;
    instr_ready = 1'b1;
    q.delete();
    push_run(20, 64);
    check("bf_addr", ram_addr, 32'd20);
    tick();
    check("bf_gap", {31'd0, instr_valid}, 32'd0);
    tick();
    check("bf_valid", {31'd0, instr_valid}, 32'd1);
    check("bf_pc", instr_pc, 32'd20);
    check("bf_instr", instr, 32'h114);
    tick();
    check("bf_next_pc", instr_pc, 32'd21);
    for (int i = 0; i < 4; i++) tick();
    // branch in the same cycle as the pop of PC 2
    do_reset();
    push_run(0, 64);
    for (int i = 0; i < 5; i++) tick();
    check("bh_head", instr_pc, 32'd2);
    branch_taken = 1'b1;
    branch_target = 32'd40;
    tick();
    branch_taken = 1'b0;
    check("bh_consumed", 32'(q.size()), 32'd61);
    q.delete();
    push_run(40, 64);
    tick();
    check("bh_gap", {31'd0, instr_valid}, 32'd0);
    tick();
    check("bh_pc", instr_pc, 32'd40);
    for (int i = 0; i < 4; i++) tick();
    // reset while the FIFO holds three words
    instr_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    check("mid_valid", {31'd0, instr_valid}, 32'd1);
    check("mid_pc", instr_pc, 32'd0);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("mid");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    push_run(0, 64);
    instr_ready = 1'b1;
    cyc = 0;
    while (!instr_valid && cyc < 10) begin
      tick();
      cyc++;
    end
    check("mid_latency", 32'(cyc), 32'd3);
    check("mid_restart_pc", instr_pc, 32'd0);
    for (int i = 0; i < 4; i++) tick();
    // wrap-around instance ran its first four words after the first release
    check("wrap_count", 32'(wq.size()), 32'd4);
    if (wq.size() == 4) begin
      check("wrap_pc0", wq[0], 32'hFFFF_FFFE);
      check("wrap_pc1", wq[1], 32'hFFFF_FFFF);
      check("wrap_pc2", wq[2], 32'd0);
      check("wrap_pc3", wq[3], 32'd1);
      check("wrap_i0", wi[0], 32'h0000_00FE);
      check("wrap_i2", wi[2], 32'h0000_0100);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage that sits directly upstream of the `ram` block. It owns the program counter and drives the RAM address and control ports in read-only mode. It captures each instruction word from the RAM `FETCH` port into a small prefetch FIFO and presents the words to decode over a valid/ready handshake. Taken branches redirect the PC and flush all buffered and in-flight words.

## Interface
- `RESET_VECTOR`, default 32'd0: PC value after reset (RAM word address).
- `DEPTH`, default 4: prefetch FIFO entries. Power of two, ≥2; full throughput requires ≥4.
- `CLK` input 1: rising-edge clock, shared with `ram`.
- `RST_N` input 1: asynchronous, active-low reset.
- `RAM_ADDR` output 32: word address to `ram` ADDR.
- `RAM_RW` output 2: to `ram` RW; 2'b01 = read, 2'b00 = idle; never any other value.
- `RAM_ENABLE` output 1: to `ram` ENABLE.
- `RAM_FETCH` input 32: from `ram` FETCH.
- `BRANCH_TAKEN` input 1: redirect request, single-cycle pulse.
- `BRANCH_TARGET` input 32: new PC, sampled when `BRANCH_TAKEN`=1.
- `INSTR` output 32: instruction word at FIFO head.
- `INSTR_PC` output 32: word address of `INSTR`.
- `INSTR_VALID` output 1: head entry valid.
- `INSTR_READY` input 1: decode accepts the head word when `INSTR_VALID`=1.

## Operation
- **RAM contract:** `ENABLE`=1 and `RW`=01 sampled at edge k make `FETCH`=mem[ADDR] valid from edge k until the next read edge.
- **Registered outputs:** all RAM-side outputs are registered.
- **Request pipeline:**
  - Stage R: request registers drive the RAM.
  - Stage W: the response is written to the FIFO at the edge after the RAM read.
  - Each stage carries a valid bit, the request PC and an epoch bit.
- **Issue rule:** a read is issued, loading `RAM_ADDR`=PC, `RAM_ENABLE`=1, `RAM_RW`=01 and then PC←PC+1, only when fifo_count + inflight < DEPTH.
  - inflight counts valid stage R and stage W entries.
  - If no read is issued that cycle: `RAM_ENABLE`=0, `RAM_RW`=00, `RAM_ADDR` holds.
- **FIFO write:** stage W writes {`RAM_FETCH`, pc} when its valid bit is set and its epoch equals the current epoch.
- **FIFO pop:** on `INSTR_VALID` && `INSTR_READY`.
  - Write and pop may occur in the same cycle, including when the FIFO is full.
- **Branch:** on the edge with `BRANCH_TAKEN`=1:
  - The epoch toggles and FIFO count clears to 0.
  - Stage R/W contents become stale and are discarded at write time.
  - PC←`BRANCH_TARGET`.
  - The issue check that cycle uses count=0 and inflight=0, so the target read is issued at this same edge.
  - A handshake in the same cycle as `BRANCH_TAKEN` still counts as consumed by decode; the branch has priority over all other updates.
- **Wrap-around:**
  - PC wraps modulo 2^32: 32'hFFFFFFFF + 1 = 0.
  - FIFO pointers wrap modulo DEPTH.
- **Full FIFO:** issue stops. Words already in flight are guaranteed space because they were counted in the issue rule, so no overflow is possible.
- **Empty FIFO:** `INSTR_VALID`=0. `INSTR` and `INSTR_PC` hold their last values and are don't-care for decode.

## Timing
- **Reset values (asynchronous):**
  - `RAM_ENABLE`=0, `RAM_RW`=2'b00, `RAM_ADDR`=`RESET_VECTOR`.
  - `INSTR_VALID`=0, `INSTR`=0, `INSTR_PC`=0.
  - PC=`RESET_VECTOR`, FIFO empty, stage R and W invalid, epoch=0.
- **Reset mid-operation:** immediately returns everything to the reset state. In-flight reads are lost and the RAM is not corrupted, since the block never writes.
- **Startup latency:**
  - Edge 1 after `RST_N` rises: first request registered.
  - Edge 2: RAM reads.
  - Edge 3: FIFO written; `INSTR_VALID`=1 after edge 3.
- **Throughput:** with `INSTR_READY` held at 1 and DEPTH≥4, one instruction per cycle after startup.
- **Redirect latency:** the target word is valid 2 edges after the branch edge.
  - `INSTR_VALID`=0 for the cycles between the branch edge and that point.
- **FIFO timing:** `INSTR` and `INSTR_PC` change only on a pop or on a write into an empty FIFO.
- **Back-pressure:** when `INSTR_READY`=0, the FIFO fills to DEPTH, then `RAM_ENABLE`=0 within 1 cycle.

## Test plan
- **Reset/startup:** RAM loaded with mem[i]=i+32'h100, `INSTR_READY`=1. Release `RST_N` → `INSTR_VALID` rises after edge 3. Words then appear back-to-back, one per cycle: 0x100/PC0, 0x101/PC1, … 0x107/PC7, with no gaps.
- **Back-pressure:** hold `INSTR_READY`=0 from the start → exactly 4 reads issued (ADDR 0..3), then `RAM_ENABLE`=0. Release → PCs 0..3 delivered in order, then fetch resumes at ADDR 4 without loss or duplication.
- **Branch flush:** pulse `BRANCH_TAKEN` with target 32'd20 while PCs 2..5 are buffered or in flight → PCs 3..5 are never presented. The next valid word is mem[20] with `INSTR_PC`=20, 2 edges later; the following word is PC 21.
- **Branch + handshake:** assert `BRANCH_TAKEN` in the same cycle as a pop of PC 2 → PC 2 counts as consumed, and the next presented word is the target.
- **Wrap-around:** set `RESET_VECTOR`=32'hFFFFFFFE → PCs FFFFFFFE, FFFFFFFF, 0, 1 in sequence.
- **Reset mid-stream:** drop `RST_N` while the FIFO holds 3 entries → all outputs take their reset values asynchronously. After release, fetch restarts at `RESET_VECTOR` with startup latency 3.
